// File: rtl/interface_controller_out.sv
// interface_controller_out
// Read side of the host command FIFO. Pops bytes through a two-entry
// read-return skid buffer (the FIFO has one cycle of read latency),
// decodes connect / disconnect / send_data commands, and streams
// send_data payloads to the parser with SOP/EOP and valid/ready flow control.
//
// Optional feature, enabled by defining CONN_TRACK_EN:
//   keeps a per-host connection bitmap. A send_data to an unconnected host
//   raises err_o, and its length and payload bytes are consumed and dropped.
//   A repeated connect, or a disconnect of an unconnected host, raises err_o
//   and still emits the event.
// In the default build (CONN_TRACK_EN undefined), every send_data frame is
// forwarded.
//
// HOST_ADDR_WIDTH must be 1..4. SKID_DEPTH must be 2.
module interface_controller_out #(
  parameter int HOST_ADDR_WIDTH = 4,
  parameter int SKID_DEPTH      = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       empty_i,
  input  logic [7:0]                 data_i,
  output logic                       readreq_o,
  output logic                       connect_o,
  output logic                       disconnect_o,
  output logic [HOST_ADDR_WIDTH-1:0] host_addr_o,
  output logic                       msg_valid_o,
  input  logic                       msg_ready_i,
  output logic [7:0]                 msg_data_o,
  output logic                       msg_sop_o,
  output logic                       msg_eop_o,
  output logic [7:0]                 msg_len_o,
  output logic                       err_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  localparam logic [2:0] OP_CONNECT    = 3'b000;
  localparam logic [2:0] OP_DISCONNECT = 3'b001;
  localparam logic [2:0] OP_SEND_DATA  = 3'b010;
  localparam logic [1:0] SKID_MAX      = 2'(SKID_DEPTH);

  state_t state;

  // Read-return skid buffer.
  logic [7:0] skid_mem [SKID_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] skid_cnt;
  logic       in_flight;
  logic       active;  // low during reset, and for one cycle after, so no read is issued then

  logic [1:0] occupancy;
  logic       head_valid;
  logic [7:0] head_data;
  logic       out_free;
  logic       pop;
  logic       pop_mem;
  logic       push;
  logic [HOST_ADDR_WIDTH-1:0] cmd_addr;

  logic [7:0] byte_cnt;    // payload bytes still to load into the output register
  logic       first_byte;  // the next payload byte loaded is the first of its frame
  logic       drop;        // the current frame is being discarded

`ifdef CONN_TRACK_EN
  logic [2**HOST_ADDR_WIDTH-1:0] conn_map;
`else
  assign drop = 1'b0;
`endif

  // The head is the oldest buffered byte. When the buffer is empty, the head
  // is the byte arriving from the FIFO this cycle, which keeps the full
  // byte-per-cycle rate.
  assign occupancy  = skid_cnt + {1'b0, in_flight};
  assign head_valid = (skid_cnt != 2'd0) || in_flight;
  assign head_data  = (skid_cnt != 2'd0) ? skid_mem[rd_ptr] : data_i;
  assign cmd_addr   = head_data[3 +: HOST_ADDR_WIDTH];
  assign out_free   = !msg_valid_o || msg_ready_i;

  assign readreq_o  = active && !empty_i && (occupancy < SKID_MAX);

  // Decide whether the head byte is consumed this cycle.
  always_comb begin
    // NOTE: give every always_comb output a default first, so no path leaves it unassigned and infers a latch.
    pop = 1'b0;
    unique case (state)
      IDLE, LEN: pop = head_valid;
      PAYLOAD:   pop = head_valid && (byte_cnt != 8'd0) && (drop || out_free);
      default:   pop = 1'b0;
    endcase
  end

  // A returning byte is stored unless it is consumed through the bypass in the same cycle.
  assign pop_mem = pop && (skid_cnt != 2'd0);
  assign push    = in_flight && !((skid_cnt == 2'd0) && pop);

  // Skid buffer storage.
  // NOTE: the data array has no reset; the pointers and count decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) skid_mem[wr_ptr] <= data_i;
  end

  // Skid buffer pointers and count, the read-in-flight flag, and the startup gate.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      skid_cnt  <= 2'd0;
      in_flight <= 1'b0;
      active    <= 1'b0;
    end else begin
      active    <= 1'b1;
      in_flight <= readreq_o;
      if (push)    wr_ptr <= ~wr_ptr;
      if (pop_mem) rd_ptr <= ~rd_ptr;
      skid_cnt <= skid_cnt + {1'b0, push} - {1'b0, pop_mem};
    end
  end

  // Command decoder and payload streamer; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      connect_o    <= 1'b0;
      disconnect_o <= 1'b0;
      err_o        <= 1'b0;
      host_addr_o  <= '0;
      msg_valid_o  <= 1'b0;
      msg_data_o   <= 8'd0;
      msg_sop_o    <= 1'b0;
      msg_eop_o    <= 1'b0;
      msg_len_o    <= 8'd0;
      byte_cnt     <= 8'd0;
      first_byte   <= 1'b0;
`ifdef CONN_TRACK_EN
      drop         <= 1'b0;
      conn_map     <= '0;
`endif
    end else begin
      connect_o    <= 1'b0;
      disconnect_o <= 1'b0;
      err_o        <= 1'b0;

      // An accepted beat empties the output register unless a new byte is loaded below.
      if (msg_valid_o && msg_ready_i) begin
        msg_valid_o <= 1'b0;
        msg_sop_o   <= 1'b0;
        msg_eop_o   <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (pop) begin
            if (head_data[7] || (head_data[2:0] > OP_SEND_DATA)) begin
              err_o <= 1'b1;
            end else begin
              host_addr_o <= cmd_addr;
              unique case (head_data[2:0])
                OP_CONNECT: begin
                  connect_o <= 1'b1;
`ifdef CONN_TRACK_EN
                  if (conn_map[cmd_addr]) err_o <= 1'b1;
                  conn_map[cmd_addr] <= 1'b1;
`endif
                end
                OP_DISCONNECT: begin
                  disconnect_o <= 1'b1;
`ifdef CONN_TRACK_EN
                  if (!conn_map[cmd_addr]) err_o <= 1'b1;
                  conn_map[cmd_addr] <= 1'b0;
`endif
                end
                default: begin
                  state <= LEN;
`ifdef CONN_TRACK_EN
                  drop <= !conn_map[cmd_addr];
                  if (!conn_map[cmd_addr]) err_o <= 1'b1;
`endif
                end
              endcase
            end
          end
        end

        LEN: begin
          if (pop) begin
            msg_len_o  <= head_data;
            byte_cnt   <= head_data;
            first_byte <= 1'b1;
            if (head_data == 8'd0) begin
              err_o <= 1'b1;
              state <= IDLE;
            end else begin
              state <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (pop) begin
            byte_cnt <= byte_cnt - 8'd1;
            if (!drop) begin
              msg_valid_o <= 1'b1;
              msg_data_o  <= head_data;
              msg_sop_o   <= first_byte;
              msg_eop_o   <= (byte_cnt == 8'd1);
              first_byte  <= 1'b0;
            end else if (byte_cnt == 8'd1) begin
              state <= IDLE;
            end
          end
          if (!drop && msg_valid_o && msg_ready_i && msg_eop_o) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
